// File: rtl/dmem_responder.sv
// Single-port data memory responder: accepts one load/store at a time, waits a
// fixed number of cycles, then holds its response until the initiator takes it.
module dmem_responder #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshakes: a request transfers on a rising edge with req_valid && req_ready;
    // a response transfers on a rising edge with resp_valid && resp_ready, and
    // resp_* stay stable from resp_valid rising until that transfer.

    localparam int         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit         ZERO_WAIT  = (WAIT == 0);
    localparam logic [3:0] WAIT_LOAD  = ZERO_WAIT ? 4'd0 : 4'(WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_rdata;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_mem [DEPTH];

    logic        w_accept;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_err;
    logic [AW-1:0] w_idx;
    logic        w_enter_resp;
    logic        w_mem_we;
    logic [31:0] w_rdata_next;

    // In IDLE the live inputs are used so a zero-wait access can complete on
    // its own acceptance edge; otherwise the captured request is used.
    always_comb begin
        w_accept     = (r_state == S_IDLE) && r_req_ready && req_valid;
        w_we         = (r_state == S_IDLE) ? req_we    : r_we;
        w_addr       = (r_state == S_IDLE) ? req_addr  : r_addr;
        w_wdata      = (r_state == S_IDLE) ? req_wdata : r_wdata;
        w_err        = (w_addr[1:0] != 2'b00) || ({2'b00, w_addr[31:2]} >= 32'(DEPTH));
        w_idx        = w_addr[AW+1:2];
        w_enter_resp = reset && ((w_accept && ZERO_WAIT) ||
                                 ((r_state == S_WAIT) && (r_cnt == 4'd0)));
        w_mem_we     = w_enter_resp && w_we && !w_err;
        w_rdata_next = 32'd0;
        if (!w_we && !w_err) begin
            w_rdata_next = r_mem[w_idx];
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_rdata      <= 32'd0;
            r_we         <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        if (ZERO_WAIT) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= w_err;
                            r_rdata      <= w_rdata_next;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= WAIT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= w_err;
                        r_rdata      <= w_rdata_next;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_rdata      <= 32'd0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_rdata;
    assign busy       = (r_state != S_IDLE);
    assign dbg_state  = r_state;

endmodule
